// File: rtl/ctrl_tx_if.sv
// rtl/ctrl_tx_if.sv - ctrl request bundle between ctrl initiators and the ctrl_tx responder
interface ctrl_tx_if;
    logic [7:0]  ctrl_opcode;
    logic [7:0]  ctrl_chipid;
    logic [15:0] ctrl_addr;
    logic [15:0] ctrl_data;
    logic        ctrl_wr;
    logic        ctrl_ack;
    logic        busy;

    modport master (
        output ctrl_opcode, ctrl_chipid, ctrl_addr, ctrl_data, ctrl_wr,
        input  ctrl_ack, busy
    );

    modport slave (
        input  ctrl_opcode, ctrl_chipid, ctrl_addr, ctrl_data, ctrl_wr,
        output ctrl_ack, busy
    );
endinterface

// File: rtl/ctrl_tx.sv
// rtl/ctrl_tx.sv - ctrl request responder serialising requests onto the ALPIDE DCTRL line
// Optional transaction counters enabled by defining CTRL_TX_STATS_EN.
module ctrl_tx #(
    parameter int CLKDIV    = 4,
    parameter int IDLE_BITS = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    ctrl_tx_if.slave    req,
    output logic        dctrl_o,
    output logic        dctrl_oe_o,
    input  logic        reg_we_i,
    input  logic [7:0]  reg_addr_i,
    input  logic [15:0] reg_data_i,
    output logic [15:0] reg_data_o
);
    localparam logic [7:0] WROP = 8'h9C;
    localparam logic [7:0] RDOP = 8'h4E;
    localparam int DIV_W     = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int CHAR_BITS = 10 + IDLE_BITS;
    localparam int BIT_W     = $clog2(CHAR_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [7:0]       op_q, chip_q;
    logic [15:0]      addr_q, data_q;
    logic [DIV_W-1:0] div_q;
    logic [BIT_W-1:0] bit_q;
    logic [2:0]       byte_q;

    logic             accept;
    logic             is_wrop;
    logic             div_last, bit_last, byte_last;
    logic [7:0]       cur_byte;
    logic [BIT_W-1:0] data_idx;
    logic             bit_val;

    assign accept    = (state_q == ST_IDLE) && req.ctrl_wr;
    assign is_wrop   = (op_q == WROP);
    assign div_last  = (div_q == DIV_W'(CLKDIV - 1));
    assign bit_last  = (bit_q == BIT_W'(CHAR_BITS - 1));
    assign byte_last = (byte_q == (is_wrop ? 3'd5 : 3'd0));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req.ctrl_wr) begin
                    state_d = (req.ctrl_opcode == RDOP) ? ST_ACK : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (div_last && bit_last && byte_last) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields are frozen at accept so the initiator may move on early.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q   <= 8'h00;
            chip_q <= 8'h00;
            addr_q <= 16'h0000;
            data_q <= 16'h0000;
        end else if (accept) begin
            op_q   <= req.ctrl_opcode;
            chip_q <= req.ctrl_chipid;
            addr_q <= req.ctrl_addr;
            data_q <= req.ctrl_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q  <= '0;
            bit_q  <= '0;
            byte_q <= 3'd0;
        end else if (state_q == ST_SHIFT) begin
            if (div_last) begin
                div_q <= '0;
                if (bit_last) begin
                    bit_q  <= '0;
                    byte_q <= byte_last ? 3'd0 : byte_q + 3'd1;
                end else begin
                    bit_q <= bit_q + BIT_W'(1);
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end else begin
            div_q  <= '0;
            bit_q  <= '0;
            byte_q <= 3'd0;
        end
    end

    always_comb begin
        case (byte_q)
            3'd0:    cur_byte = op_q;
            3'd1:    cur_byte = chip_q;
            3'd2:    cur_byte = addr_q[7:0];
            3'd3:    cur_byte = addr_q[15:8];
            3'd4:    cur_byte = data_q[7:0];
            3'd5:    cur_byte = data_q[15:8];
            default: cur_byte = op_q;
        endcase
    end

    // Bit period 0 is the start bit, 1..8 carry data LSB-first, the rest are stop and idle gap.
    assign data_idx = bit_q - BIT_W'(1);

    always_comb begin
        if (bit_q == '0) begin
            bit_val = 1'b0;
        end else if (bit_q <= BIT_W'(8)) begin
            bit_val = cur_byte[data_idx[2:0]];
        end else begin
            bit_val = 1'b1;
        end
    end

    assign dctrl_o      = (state_q == ST_SHIFT) ? bit_val : 1'b1;
    assign dctrl_oe_o   = (state_q == ST_SHIFT);
    assign req.ctrl_ack = (state_q == ST_ACK);
    assign req.busy     = (state_q != ST_IDLE);

`ifdef CTRL_TX_STATS_EN
    logic [15:0] nwrop_q, ncmd_q, nrej_q;
    logic        clr;

    assign clr = reg_we_i && (reg_addr_i == 8'h01) && (reg_data_i == 16'h0002);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            nwrop_q <= 16'h0000;
            ncmd_q  <= 16'h0000;
            nrej_q  <= 16'h0000;
        end else if (clr) begin
            nwrop_q <= 16'h0000;
            ncmd_q  <= 16'h0000;
            nrej_q  <= 16'h0000;
        end else if (state_q == ST_ACK) begin
            if (op_q == WROP) begin
                if (nwrop_q != 16'hFFFF) nwrop_q <= nwrop_q + 16'd1;
            end else if (op_q == RDOP) begin
                if (nrej_q != 16'hFFFF) nrej_q <= nrej_q + 16'd1;
            end else begin
                if (ncmd_q != 16'hFFFF) ncmd_q <= ncmd_q + 16'd1;
            end
        end
    end
`else
    logic unused_reg_wr;
    assign unused_reg_wr = ^{reg_we_i, reg_data_i};
`endif

    always_comb begin
        case (reg_addr_i)
            8'h00:   reg_data_o = {14'b0, state_q};
`ifdef CTRL_TX_STATS_EN
            8'h02:   reg_data_o = nwrop_q;
            8'h03:   reg_data_o = ncmd_q;
            8'h04:   reg_data_o = nrej_q;
`endif
            default: reg_data_o = 16'hF001;
        endcase
    end
endmodule

// File: tb/tb_ctrl_tx.sv
// tb/tb_ctrl_tx.sv - directed self-checking bench for ctrl_tx
module tb_ctrl_tx;
    localparam int CLKDIV    = 4;
    localparam int IDLE_BITS = 2;
    localparam int CB        = 10 + IDLE_BITS;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dctrl_o, dctrl_oe_o;
    logic        reg_we_i;
    logic [7:0]  reg_addr_i;
    logic [15:0] reg_data_i, reg_data_o;

    int tests = 0;
    int fails = 0;
    int exp_nwrop = 0, exp_ncmd = 0, exp_nrej = 0;

    always #5 clk_i = ~clk_i;

    ctrl_tx_if bus ();

    ctrl_tx #(.CLKDIV(CLKDIV), .IDLE_BITS(IDLE_BITS)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req        (bus.slave),
        .dctrl_o    (dctrl_o),
        .dctrl_oe_o (dctrl_oe_o),
        .reg_we_i   (reg_we_i),
        .reg_addr_i (reg_addr_i),
        .reg_data_i (reg_data_i),
        .reg_data_o (reg_data_o)
    );

    function automatic logic [7:0] model_byte(input logic [7:0] op, input logic [7:0] chip,
                                              input logic [15:0] addr, input logic [15:0] data,
                                              input int idx);
        case (idx)
            0: return op;
            1: return chip;
            2: return addr[7:0];
            3: return addr[15:8];
            4: return data[7:0];
            default: return data[15:8];
        endcase
    endfunction

    function automatic int model_nchar(input logic [7:0] op);
        if (op == 8'h9C) return 6;
        if (op == 8'h4E) return 0;
        return 1;
    endfunction

    task automatic read_reg(input logic [7:0] a, output logic [15:0] v);
        reg_addr_i = a;
        #1;
        v = reg_data_o;
    endtask

    task automatic count_op(input logic [7:0] op);
        if (op == 8'h9C) exp_nwrop++;
        else if (op == 8'h4E) exp_nrej++;
        else exp_ncmd++;
    endtask

    task automatic check_stats(input string name);
        logic [15:0] v;
`ifdef CTRL_TX_STATS_EN
        read_reg(8'h02, v); tests++;
        if (v !== 16'(exp_nwrop)) begin fails++; $display("FAIL %s nwrop: got %h want %h", name, v, 16'(exp_nwrop)); end
        read_reg(8'h03, v); tests++;
        if (v !== 16'(exp_ncmd)) begin fails++; $display("FAIL %s ncmd: got %h want %h", name, v, 16'(exp_ncmd)); end
        read_reg(8'h04, v); tests++;
        if (v !== 16'(exp_nrej)) begin fails++; $display("FAIL %s nrej: got %h want %h", name, v, 16'(exp_nrej)); end
`else
        read_reg(8'h03, v); tests++;
        if (v !== 16'hF001) begin fails++; $display("FAIL %s ncmd absent: got %h want F001", name, v); end
`endif
    endtask

    // Called at a negedge (or in the ACK cycle of a previous request when pre_wait=1).
    task automatic run_req(input string name, input logic [7:0] op, input logic [7:0] chip,
                           input logic [15:0] addr, input logic [15:0] data,
                           input bit keep_wr, input bit pre_wait);
        int n, p, b;
        int bad_d = 0, bad_oe = 0, bad_ack = 0, bad_busy = 0;
        logic eb, e_oe, e_ack;
        logic [7:0] mb;
        logic [15:0] st;
        n = model_nchar(op) * CB * CLKDIV;
        bus.ctrl_opcode = op;
        bus.ctrl_chipid = chip;
        bus.ctrl_addr   = addr;
        bus.ctrl_data   = data;
        bus.ctrl_wr     = 1'b1;
        if (pre_wait) @(posedge clk_i);
        @(posedge clk_i);
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk_i);
            if (c <= n) begin
                p = (c - 1) / CLKDIV;
                b = p % CB;
                mb = model_byte(op, chip, addr, data, p / CB);
                eb = (b == 0) ? 1'b0 : ((b <= 8) ? mb[b-1] : 1'b1);
                e_oe = 1'b1;
                e_ack = 1'b0;
            end else begin
                eb = 1'b1;
                e_oe = 1'b0;
                e_ack = 1'b1;
            end
            if (dctrl_o !== eb) bad_d++;
            if (dctrl_oe_o !== e_oe) bad_oe++;
            if (bus.ctrl_ack !== e_ack) bad_ack++;
            if (bus.busy !== 1'b1) bad_busy++;
            if (n > 0 && c == n / 2) begin
                bus.ctrl_opcode = ~op;
                bus.ctrl_chipid = ~chip;
                bus.ctrl_addr   = ~addr;
                bus.ctrl_data   = ~data;
            end
            if (n > 20 && c == 10) begin
                read_reg(8'h00, st); tests++;
                if (st !== 16'h0001) begin fails++; $display("FAIL %s status shift: got %h want 0001", name, st); end
            end
            if (c == n + 1) begin
                read_reg(8'h00, st); tests++;
                if (st !== 16'h0002) begin fails++; $display("FAIL %s status ack: got %h want 0002", name, st); end
                if (!keep_wr) bus.ctrl_wr = 1'b0;
            end
        end
        tests++;
        if (bad_d != 0) begin fails++; $display("FAIL %s dctrl: %0d bad cycles, want 0", name, bad_d); end
        tests++;
        if (bad_oe != 0) begin fails++; $display("FAIL %s oe: %0d bad cycles, want 0", name, bad_oe); end
        tests++;
        if (bad_ack != 0) begin fails++; $display("FAIL %s ack timing: %0d bad cycles, want 0 (ack at +%0d)", name, bad_ack, n + 1); end
        tests++;
        if (bad_busy != 0) begin fails++; $display("FAIL %s busy: %0d bad cycles, want 0", name, bad_busy); end
        count_op(op);
        if (!keep_wr) begin
            @(negedge clk_i);
            tests++;
            if (bus.ctrl_ack !== 1'b0 || bus.busy !== 1'b0 || dctrl_o !== 1'b1 || dctrl_oe_o !== 1'b0) begin
                fails++;
                $display("FAIL %s after ack: ack=%b busy=%b dctrl=%b oe=%b want 0 0 1 0",
                         name, bus.ctrl_ack, bus.busy, dctrl_o, dctrl_oe_o);
            end
        end
    endtask

    task automatic test_reset;
        logic [15:0] st;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        tests++;
        if (dctrl_o !== 1'b1 || dctrl_oe_o !== 1'b0 || bus.ctrl_ack !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset outputs: dctrl=%b oe=%b ack=%b busy=%b want 1 0 0 0",
                     dctrl_o, dctrl_oe_o, bus.ctrl_ack, bus.busy);
        end
        read_reg(8'h00, st); tests++;
        if (st !== 16'h0000) begin fails++; $display("FAIL reset status: got %h want 0000", st); end
        exp_nwrop = 0; exp_ncmd = 0; exp_nrej = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_stats("reset");
    endtask

    task automatic test_wrop;
        @(negedge clk_i);
        run_req("wrop", 8'h9C, 8'h0F, 16'h0000, 16'hFF10, 1'b0, 1'b0);
        check_stats("wrop");
    endtask

    task automatic test_cmd;
        run_req("cmd55", 8'h55, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check_stats("cmd55");
    endtask

    task automatic test_rdop;
        run_req("rdop", 8'h4E, 8'h12, 16'h3456, 16'h789A, 1'b0, 1'b0);
        check_stats("rdop");
    endtask

    task automatic test_back_to_back;
        run_req("b2b_first", 8'h9C, 8'h0F, 16'h0000, 16'hFF10, 1'b1, 1'b0);
        run_req("b2b_second", 8'h9C, 8'h0F, 16'h0000, 16'hFF11, 1'b0, 1'b1);
        check_stats("b2b");
    endtask

    task automatic test_reset_midframe;
        int bad_ack = 0;
        bus.ctrl_opcode = 8'h9C;
        bus.ctrl_chipid = 8'hA0;
        bus.ctrl_addr   = 16'h0000;
        bus.ctrl_data   = 16'hFF10;
        bus.ctrl_wr     = 1'b1;
        @(posedge clk_i);
        // chipid 0xA0 data bit 2 is 0, so the line is low just before reset
        repeat (62) @(negedge clk_i);
        tests++;
        if (dctrl_o !== 1'b0 || dctrl_oe_o !== 1'b1) begin
            fails++; $display("FAIL midframe pre-reset: dctrl=%b oe=%b want 0 1", dctrl_o, dctrl_oe_o);
        end
        rst_i = 1'b1;
        bus.ctrl_wr = 1'b0;
        #1;
        tests++;
        if (dctrl_o !== 1'b1 || dctrl_oe_o !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL midframe async reset: dctrl=%b oe=%b busy=%b want 1 0 0", dctrl_o, dctrl_oe_o, bus.busy);
        end
        exp_nwrop = 0; exp_ncmd = 0; exp_nrej = 0;
        repeat (2) begin
            @(negedge clk_i);
            if (bus.ctrl_ack !== 1'b0) bad_ack++;
        end
        rst_i = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            if (bus.ctrl_ack !== 1'b0 || dctrl_o !== 1'b1) bad_ack++;
        end
        tests++;
        if (bad_ack != 0) begin fails++; $display("FAIL midframe no ack: %0d bad cycles, want 0", bad_ack); end
        run_req("post_reset_wrop", 8'h9C, 8'h0F, 16'h0000, 16'hFF10, 1'b0, 1'b0);
        check_stats("post_reset");
    endtask

    task automatic test_regs;
        logic [15:0] v;
        read_reg(8'h10, v); tests++;
        if (v !== 16'hF001) begin fails++; $display("FAIL unmapped read: got %h want F001", v); end
        // CLR written in the ACK cycle of a command must leave the counters at zero
        bus.ctrl_opcode = 8'h55;
        bus.ctrl_wr = 1'b1;
        @(posedge clk_i);
        repeat (CB * CLKDIV + 1) @(negedge clk_i);
        bus.ctrl_wr = 1'b0;
        tests++;
        if (bus.ctrl_ack !== 1'b1) begin fails++; $display("FAIL clr collision ack: got %b want 1", bus.ctrl_ack); end
        reg_we_i = 1'b1;
        reg_addr_i = 8'h01;
        reg_data_i = 16'h0002;
        @(negedge clk_i);
        reg_we_i = 1'b0;
`ifdef CTRL_TX_STATS_EN
        exp_nwrop = 0; exp_ncmd = 0; exp_nrej = 0;
`else
        count_op(8'h55);
`endif
        check_stats("clr");
        read_reg(8'h00, v); tests++;
        if (v !== 16'h0000) begin fails++; $display("FAIL status after clr: got %h want 0000", v); end
    endtask

    initial begin
        rst_i = 1'b1;
        reg_we_i = 1'b0;
        reg_addr_i = 8'h00;
        reg_data_i = 16'h0000;
        bus.ctrl_opcode = 8'h00;
        bus.ctrl_chipid = 8'h00;
        bus.ctrl_addr = 16'h0000;
        bus.ctrl_data = 16'h0000;
        bus.ctrl_wr = 1'b0;
        test_reset;
        test_wrop;
        test_cmd;
        test_rdop;
        test_back_to_back;
        test_reset_midframe;
        test_regs;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
